// File: rtl/tdc_sample_queue.sv
// Sample FIFO and one-at-a-time launch controller feeding the 40-bit hex UART.
// Counts samples dropped on overflow so gaps in the record are visible to the host.
module tdc_sample_queue #(
    parameter int DATA_W = 40,
    parameter int ADDR_W = 4,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              tx_busy,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [DROP_W-1:0] DROP_ONE = 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WSTART = 2'd2;
    localparam logic [1:0] S_WDONE  = 2'd3;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              wait_q, wait_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic pop;
    logic wr;
    logic drop;

    assign pop  = (state_q == S_IDLE) && (count_q != '0) && !tx_busy;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr   = in_valid && ((count_q != CNT_FULL) || pop);
    assign drop = in_valid && !wr;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        wait_d     = wait_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        ovf_d      = ovf_q;
        drop_d     = drop_q;

        if (wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !wr) begin
            count_d = count_q - CNT_ONE;
        end

        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_ONE;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_valid_d = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wait_d  = 1'b0;
                state_d = S_WSTART;
            end
            S_WSTART: begin
                // Give up after two cycles without busy; the sample is not resent.
                if (tx_busy) begin
                    state_d = S_WDONE;
                end else if (wait_q) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_WDONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            wait_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            wait_q     <= wait_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_tdc_sample_queue.sv
// Scoreboard bench for tdc_sample_queue with a simple transmitter busy model.
// Directed scenarios push expected samples; a negedge monitor checks each strobe.
module tb_tdc_sample_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        tx_busy;
    logic [39:0] tx_data;
    logic        tx_valid;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;
    int n_strobe = 0;
    int busy_len = 20;
    int busy_cnt = 0;
    logic hold_busy = 1'b0;
    logic prev_valid = 1'b0;
    logic [39:0] exp_q [$];

    tdc_sample_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    assign tx_busy = hold_busy | (busy_cnt != 0);

    always @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt <= 0;
        end else if (tx_valid && busy_len > 0) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && tx_valid) begin
            n_strobe++;
            check("strobe_not_back_to_back", {63'd0, prev_valid}, 64'd0);
            check("strobe_while_idle", {63'd0, tx_busy}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {24'd0, tx_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("tx_data_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_valid = tx_valid;
    end

    task automatic drive(input logic v, input logic [39:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic push(input logic [39:0] d);
        drive(1'b1, d);
        exp_q.push_back(d);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fifo_count != 0 || tx_busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            check({name, "_timeout"}, exp_q.size(), 64'd0);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_data", {24'd0, tx_data}, 64'd0);
        check("rst_count", {59'd0, fifo_count}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_drop", {48'd0, drop_count}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single sample latency
        push(40'h00_1234_ABCD);
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_count_after_write", {59'd0, fifo_count}, 64'd1);
        check("t1_no_early_strobe", {63'd0, tx_valid}, 64'd0);
        @(negedge clk);
        check("t1_strobe_t2", {63'd0, tx_valid}, 64'd1);
        check("t1_count_after_pop", {59'd0, fifo_count}, 64'd0);
        @(negedge clk);
        check("t1_strobe_one_cycle", {63'd0, tx_valid}, 64'd0);
        check("t1_data_held", {24'd0, tx_data}, 64'h00_1234_ABCD);
        wait_drain("t1", 200);

        // burst of five
        for (int i = 1; i <= 5; i++) push(40'(i));
        drive(1'b0, '0);
        wait_drain("t2", 400);
        check("t2_drop", {48'd0, drop_count}, 64'd0);
        check("t2_overflow", {63'd0, overflow}, 64'd0);

        // overflow with transmitter held busy
        hold_busy = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) push(40'(100 + i));
            else drive(1'b1, 40'(100 + i));
        end
        drive(1'b0, '0);
        check("t3_count_full", {59'd0, fifo_count}, 64'd16);
        check("t3_drop", {48'd0, drop_count}, 64'd2);
        check("t3_overflow", {63'd0, overflow}, 64'd1);
        hold_busy = 1'b0;
        wait_drain("t3", 1000);

        // full FIFO with write in the pop cycle
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(40'(200 + i));
        drive(1'b0, '0);
        check("t4_count_full", {59'd0, fifo_count}, 64'd16);
        @(negedge clk);
        hold_busy = 1'b0;
        in_valid  = 1'b1;
        in_data   = 40'd216;
        exp_q.push_back(40'd216);
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_count_stays", {59'd0, fifo_count}, 64'd16);
        check("t4_drop_same", {48'd0, drop_count}, 64'd2);
        wait_drain("t4", 1000);

        // wrap-around: 40 samples in bursts of ten
        busy_len = 3;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) push(40'hA0_0000_0000 + 40'(b * 10 + i));
            drive(1'b0, '0);
            wait_drain("t5", 300);
        end
        check("t5_drop", {48'd0, drop_count}, 64'd2);

        // lost handshake: transmitter never goes busy
        busy_len = 0;
        n_strobe = 0;
        for (int i = 0; i < 3; i++) push(40'hC0 + 40'(i));
        drive(1'b0, '0);
        wait_drain("t7", 100);
        push(40'hC_AFE0);
        drive(1'b0, '0);
        wait_drain("t7_again", 100);
        check("t7_strobes", n_strobe, 64'd4);

        // reset in WAIT_DONE with three queued
        busy_len = 20;
        push(40'hD0);
        for (int i = 1; i < 4; i++) drive(1'b1, 40'hD0 + 40'(i));
        drive(1'b0, '0);
        repeat (4) @(negedge clk);
        check("t6_first_sent", exp_q.size(), 64'd0);
        check("t6_busy", {63'd0, tx_busy}, 64'd1);
        check("t6_queued", {59'd0, fifo_count}, 64'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_count", {59'd0, fifo_count}, 64'd0);
        check("t6_rst_data", {24'd0, tx_data}, 64'd0);
        check("t6_rst_valid", {63'd0, tx_valid}, 64'd0);
        check("t6_rst_overflow", {63'd0, overflow}, 64'd0);
        check("t6_rst_drop", {48'd0, drop_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_strobe = 0;
        repeat (60) @(negedge clk);
        check("t6_no_strobe", n_strobe, 64'd0);
        check("t6_count_zero", {59'd0, fifo_count}, 64'd0);

        check("final_queue_empty", exp_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
